// File: rtl/alarm_clock_pkg.sv
// Shared constants, types and limit helper for the alarm clock time path.
package alarm_clock_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned IDX_W      = 3;

    localparam logic [IDX_W-1:0] SEC_U = 3'd0;
    localparam logic [IDX_W-1:0] SEC_T = 3'd1;
    localparam logic [IDX_W-1:0] MIN_U = 3'd2;
    localparam logic [IDX_W-1:0] MIN_T = 3'd3;
    localparam logic [IDX_W-1:0] HR_U  = 3'd4;
    localparam logic [IDX_W-1:0] HR_T  = 3'd5;

    localparam logic [DIGIT_W-1:0] LIM_UNITS       = 4'd9;
    localparam logic [DIGIT_W-1:0] LIM_MS_TENS     = 4'd5;
    localparam logic [DIGIT_W-1:0] LIM_HR_TENS     = 4'd2;
    localparam logic [DIGIT_W-1:0] LIM_HR_UNITS_20 = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEC  = 2'd1,
        ST_MIN  = 2'd2,
        ST_HR   = 2'd3
    } tick_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] digit;
        logic             dec;
    } edit_req_t;

    // Upper bound of a digit; hour units depend on the current hour tens.
    function automatic logic [DIGIT_W-1:0] digit_limit(input logic [IDX_W-1:0] digit,
                                                       input logic [DIGIT_W-1:0] hr_tens);
        case (digit)
            SEC_T, MIN_T: digit_limit = LIM_MS_TENS;
            HR_U:         digit_limit = (hr_tens == LIM_HR_TENS) ? LIM_HR_UNITS_20 : LIM_UNITS;
            HR_T:         digit_limit = LIM_HR_TENS;
            default:      digit_limit = LIM_UNITS;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single-digit BCD increment/decrement, wrapping against a limit.
module bcd_digit_step
    import alarm_clock_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    input  logic [DIGIT_W-1:0] limit,
    input  logic               dec,
    output logic [DIGIT_W-1:0] result
);

    always_comb begin
        result = value;
        if (dec) begin
            result = (value == '0) ? limit : value - DIGIT_W'(1);
        end else begin
            result = (value >= limit) ? '0 : value + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/time_register_scheduler.sv
// HH:MM:SS BCD time registers shared between the 1 Hz carry ripple and digit edits.
module time_register_scheduler
    import alarm_clock_pkg::*;
(
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Tick,
    input  logic                  i_Edit_Active,
    input  logic [NUM_DIGITS-1:0] i_Digit_Inc,
    input  logic [NUM_DIGITS-1:0] i_Digit_Dec,
    output logic [7:0]            o_Seconds,
    output logic [7:0]            o_Minutes,
    output logic [7:0]            o_Hours,
    output logic                  o_Busy,
    output logic                  o_Rollover,
    output logic                  o_Edit_Overrun,
    output logic                  o_Tick_Overrun
);

    tick_state_e state_q, state_d;
    logic        pending_q, pending_d;
    edit_req_t   buf_q, buf_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_q, digits_d;
    logic        busy_q, busy_d;
    logic        rollover_q, rollover_d;
    logic        edit_ovr_q, edit_ovr_d;
    logic        tick_ovr_q, tick_ovr_d;

    logic             found, multi, cap_nop, cap_dec;
    logic [IDX_W-1:0] cap_digit;
    edit_req_t        cap, edit_sel;
    logic             edit_apply, tick_start;
    logic [DIGIT_W-1:0] edit_lim, edit_next;

    logic [IDX_W-1:0]   rip_u_idx, rip_t_idx;
    logic [DIGIT_W-1:0] rip_u_lim, rip_t_lim, rip_u_next, rip_t_next;
    logic               rip_u_carry, rip_t_carry;

    // Lowest-index edit request wins; inc+dec on the same digit cancels.
    always_comb begin
        found     = 1'b0;
        multi     = 1'b0;
        cap_digit = '0;
        cap_dec   = 1'b0;
        cap_nop   = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (i_Digit_Inc[k] || i_Digit_Dec[k]) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    found     = 1'b1;
                    cap_digit = IDX_W'(k);
                    cap_dec   = i_Digit_Dec[k];
                    cap_nop   = i_Digit_Inc[k] & i_Digit_Dec[k];
                end
            end
        end
        cap = '{valid: i_Edit_Active & found & ~cap_nop, digit: cap_digit, dec: cap_dec};
    end

    assign edit_sel   = buf_q.valid ? buf_q : cap;
    assign edit_apply = (state_q == ST_IDLE) && edit_sel.valid;
    assign tick_start = (state_q == ST_IDLE) && !edit_apply && !i_Edit_Active
                        && (i_Tick || pending_q);
    assign edit_lim   = digit_limit(edit_sel.digit, digits_q[HR_T]);

    bcd_digit_step u_edit_step (
        .value  (digits_q[edit_sel.digit]),
        .limit  (edit_lim),
        .dec    (edit_sel.dec),
        .result (edit_next)
    );

    // Select the units/tens pair the ripple stage works on this cycle.
    always_comb begin
        rip_u_idx = SEC_U;
        rip_t_idx = SEC_T;
        case (state_q)
            ST_MIN:  begin rip_u_idx = MIN_U; rip_t_idx = MIN_T; end
            ST_HR:   begin rip_u_idx = HR_U;  rip_t_idx = HR_T;  end
            default: ;
        endcase
    end

    assign rip_u_lim   = digit_limit(rip_u_idx, digits_q[HR_T]);
    assign rip_t_lim   = digit_limit(rip_t_idx, digits_q[HR_T]);
    assign rip_u_carry = digits_q[rip_u_idx] >= rip_u_lim;
    assign rip_t_carry = digits_q[rip_t_idx] >= rip_t_lim;

    bcd_digit_step u_rip_units (
        .value  (digits_q[rip_u_idx]),
        .limit  (rip_u_lim),
        .dec    (1'b0),
        .result (rip_u_next)
    );

    bcd_digit_step u_rip_tens (
        .value  (digits_q[rip_t_idx]),
        .limit  (rip_t_lim),
        .dec    (1'b0),
        .result (rip_t_next)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        buf_d      = buf_q;
        digits_d   = digits_q;
        rollover_d = 1'b0;
        edit_ovr_d = 1'b0;
        tick_ovr_d = 1'b0;

        if (state_q == ST_IDLE && buf_q.valid) begin
            buf_d.valid = 1'b0;
        end
        if (i_Edit_Active && multi) begin
            edit_ovr_d = 1'b1;
        end
        // Edits that cannot be applied right now go to the 1-deep buffer.
        if (cap.valid && (state_q != ST_IDLE || buf_q.valid)) begin
            if (buf_q.valid) begin
                edit_ovr_d = 1'b1;
            end else begin
                buf_d = cap;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (edit_apply) begin
                    digits_d[edit_sel.digit] = edit_next;
                    if (edit_sel.digit == HR_T && edit_next == LIM_HR_TENS
                        && digits_q[HR_U] > LIM_HR_UNITS_20) begin
                        digits_d[HR_U] = LIM_HR_UNITS_20;
                    end
                end else if (tick_start) begin
                    state_d = ST_SEC;
                end
            end
            default: begin
                digits_d[rip_u_idx] = rip_u_next;
                if (rip_u_carry) begin
                    digits_d[rip_t_idx] = rip_t_next;
                end
                if (rip_u_carry && rip_t_carry) begin
                    case (state_q)
                        ST_SEC:  state_d = ST_MIN;
                        ST_MIN:  state_d = ST_HR;
                        default: begin state_d = ST_IDLE; rollover_d = 1'b1; end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (i_Edit_Active) begin
            pending_d = 1'b0;
        end else if (i_Tick && pending_q) begin
            tick_ovr_d = 1'b1;
        end else if (i_Tick && !tick_start) begin
            pending_d = 1'b1;
        end
        if (tick_start) begin
            pending_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            buf_q      <= '0;
            digits_q   <= '0;
            busy_q     <= 1'b0;
            rollover_q <= 1'b0;
            edit_ovr_q <= 1'b0;
            tick_ovr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            buf_q      <= buf_d;
            digits_q   <= digits_d;
            busy_q     <= busy_d;
            rollover_q <= rollover_d;
            edit_ovr_q <= edit_ovr_d;
            tick_ovr_q <= tick_ovr_d;
        end
    end

    assign o_Seconds      = {digits_q[SEC_T], digits_q[SEC_U]};
    assign o_Minutes      = {digits_q[MIN_T], digits_q[MIN_U]};
    assign o_Hours        = {digits_q[HR_T], digits_q[HR_U]};
    assign o_Busy         = busy_q;
    assign o_Rollover     = rollover_q;
    assign o_Edit_Overrun = edit_ovr_q;
    assign o_Tick_Overrun = tick_ovr_q;

endmodule

// File: tb/tb_time_register_scheduler.sv
// Directed and randomized checks of time_register_scheduler against an arithmetic time model.
module tb_time_register_scheduler;

    logic       i_Clk;
    logic       i_Reset;
    logic       i_Tick;
    logic       i_Edit_Active;
    logic [5:0] i_Digit_Inc;
    logic [5:0] i_Digit_Dec;
    logic [7:0] o_Seconds;
    logic [7:0] o_Minutes;
    logic [7:0] o_Hours;
    logic       o_Busy;
    logic       o_Rollover;
    logic       o_Edit_Overrun;
    logic       o_Tick_Overrun;

    int vectors     = 0;
    int miscompares = 0;
    int m_h, m_m, m_s;

    time_register_scheduler dut (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_Tick         (i_Tick),
        .i_Edit_Active  (i_Edit_Active),
        .i_Digit_Inc    (i_Digit_Inc),
        .i_Digit_Dec    (i_Digit_Dec),
        .o_Seconds      (o_Seconds),
        .o_Minutes      (o_Minutes),
        .o_Hours        (o_Hours),
        .o_Busy         (o_Busy),
        .o_Rollover     (o_Rollover),
        .o_Edit_Overrun (o_Edit_Overrun),
        .o_Tick_Overrun (o_Tick_Overrun)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bcd(input int h, input int m, input int s);
        return {8'h00, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [31:0] obs_time();
        return {8'h00, o_Hours, o_Minutes, o_Seconds};
    endfunction

    // Digit-local edit rules applied to the model time.
    task automatic model_edit(input int k, input bit dec);
        int d[6];
        int lim[6];
        d   = '{m_s % 10, m_s / 10, m_m % 10, m_m / 10, m_h % 10, m_h / 10};
        lim = '{9, 5, 9, 5, (d[5] == 2) ? 3 : 9, 2};
        if (dec) d[k] = (d[k] == 0) ? lim[k] : d[k] - 1;
        else     d[k] = (d[k] >= lim[k]) ? 0 : d[k] + 1;
        if (k == 5 && d[5] == 2 && d[4] > 3) d[4] = 3;
        m_s = d[1] * 10 + d[0];
        m_m = d[3] * 10 + d[2];
        m_h = d[5] * 10 + d[4];
    endtask

    task automatic do_reset();
        i_Reset = 1'b1; i_Tick = 1'b0; i_Edit_Active = 1'b0;
        i_Digit_Inc = '0; i_Digit_Dec = '0;
        cyc(); cyc();
        i_Reset = 1'b0;
        m_h = 0; m_m = 0; m_s = 0;
    endtask

    task automatic edit(input int k, input bit dec);
        if (dec) i_Digit_Dec[k] = 1'b1;
        else     i_Digit_Inc[k] = 1'b1;
        cyc();
        i_Digit_Inc = '0; i_Digit_Dec = '0;
        model_edit(k, dec);
    endtask

    // Loads a time from 00:00:00 using inc pulses, tens before units.
    task automatic set_time(input int h, input int m, input int s);
        int v[6];
        v = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
        i_Edit_Active = 1'b1;
        for (int k = 5; k >= 0; k--) repeat (v[k]) edit(k, 1'b0);
    endtask

    task automatic rand_tick();
        int t;
        bit sw, mw, wrap;
        sw   = (m_s == 59);
        mw   = sw && (m_m == 59);
        wrap = mw && (m_h == 23);
        t    = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        i_Tick = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            i_Tick = 1'b0;
            chk("rnd_busy", 32'(o_Busy), 32'(c == 1 || (c == 2 && sw) || (c == 3 && mw)));
            chk("rnd_rollover", 32'(o_Rollover), 32'(c == 4 && wrap));
        end
        m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
        chk("rnd_tick_time", obs_time(), bcd(m_h, m_m, m_s));
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("reset_time", obs_time(), 32'h000000);
        chk("reset_busy", 32'(o_Busy), 0);
        chk("reset_rollover", 32'(o_Rollover), 0);
        chk("reset_edit_ovr", 32'(o_Edit_Overrun), 0);
        chk("reset_tick_ovr", 32'(o_Tick_Overrun), 0);

        // 23:59:59 rollover through full ripple
        set_time(23, 59, 59);
        chk("preload_235959", obs_time(), 32'h235959);
        i_Edit_Active = 1'b0;
        cyc();
        i_Tick = 1'b1;
        cyc(); i_Tick = 1'b0;
        chk("roll_e1_busy", 32'(o_Busy), 1);
        chk("roll_e1_time", obs_time(), 32'h235959);
        cyc();
        chk("roll_e2_busy", 32'(o_Busy), 1);
        chk("roll_e2_time", obs_time(), 32'h235900);
        cyc();
        chk("roll_e3_busy", 32'(o_Busy), 1);
        chk("roll_e3_time", obs_time(), 32'h230000);
        chk("roll_e3_pulse", 32'(o_Rollover), 0);
        cyc();
        chk("roll_e4_time", obs_time(), 32'h000000);
        chk("roll_e4_pulse", 32'(o_Rollover), 1);
        chk("roll_e4_busy", 32'(o_Busy), 0);
        cyc();
        chk("roll_e5_pulse", 32'(o_Rollover), 0);

        // Tick latency, pending tick and tick overrun
        do_reset();
        set_time(12, 34, 56);
        i_Edit_Active = 1'b0;
        i_Tick = 1'b1;
        cyc();
        chk("tick_e1_busy", 32'(o_Busy), 1);
        chk("tick_e1_time", obs_time(), 32'h123456);
        cyc();
        chk("tick_e2_time", obs_time(), 32'h123457);
        chk("tick_e2_busy", 32'(o_Busy), 0);
        chk("tick_e2_ovr", 32'(o_Tick_Overrun), 0);
        cyc(); i_Tick = 1'b0;
        chk("tick_e3_ovr", 32'(o_Tick_Overrun), 1);
        chk("tick_e3_busy", 32'(o_Busy), 1);
        cyc();
        chk("tick_e4_time", obs_time(), 32'h123458);
        chk("tick_e4_ovr", 32'(o_Tick_Overrun), 0);
        chk("tick_e4_busy", 32'(o_Busy), 0);

        // Hour tens edit clamps hour units
        do_reset();
        set_time(17, 0, 0);
        edit(5, 1'b0);
        chk("hr_clamp_23", obs_time(), 32'h230000);
        edit(5, 1'b0);
        chk("hr_wrap_03", obs_time(), 32'h030000);

        // Multiple digit requests: lowest index served
        do_reset();
        i_Edit_Active = 1'b1;
        i_Digit_Inc = 6'b000101;
        cyc(); i_Digit_Inc = '0;
        chk("multi_time", obs_time(), 32'h000001);
        chk("multi_ovr", 32'(o_Edit_Overrun), 1);
        cyc();
        chk("multi_ovr_clear", 32'(o_Edit_Overrun), 0);

        // Edit buffered during MIN, applied ahead of a pending tick
        do_reset();
        set_time(0, 59, 59);
        i_Edit_Active = 1'b0;
        i_Tick = 1'b1;
        cyc(); i_Tick = 1'b0;
        cyc();
        i_Edit_Active = 1'b1; i_Digit_Inc = 6'b000001;
        cyc();
        chk("buf_e3_time", obs_time(), 32'h000000);
        chk("buf_e3_busy", 32'(o_Busy), 1);
        chk("buf_e3_ovr", 32'(o_Edit_Overrun), 0);
        i_Edit_Active = 1'b0; i_Digit_Inc = '0; i_Tick = 1'b1;
        cyc(); i_Tick = 1'b0;
        chk("buf_e4_time", obs_time(), 32'h010000);
        chk("buf_e4_busy", 32'(o_Busy), 0);
        cyc();
        chk("buf_e5_edit_first", obs_time(), 32'h010001);
        chk("buf_e5_busy", 32'(o_Busy), 0);
        cyc();
        chk("buf_e6_busy", 32'(o_Busy), 1);
        cyc();
        chk("buf_e7_time", obs_time(), 32'h010002);

        // Second edit while buffer full is dropped
        do_reset();
        set_time(0, 0, 59);
        i_Edit_Active = 1'b0;
        i_Tick = 1'b1;
        cyc(); i_Tick = 1'b0;
        i_Edit_Active = 1'b1; i_Digit_Inc = 6'b001000;
        cyc();
        chk("bufov_e2_ovr", 32'(o_Edit_Overrun), 0);
        i_Digit_Inc = 6'b010000;
        cyc(); i_Digit_Inc = '0;
        chk("bufov_e3_ovr", 32'(o_Edit_Overrun), 1);
        chk("bufov_e3_time", obs_time(), 32'h000100);
        cyc();
        chk("bufov_e4_time", obs_time(), 32'h001100);
        chk("bufov_e4_ovr", 32'(o_Edit_Overrun), 0);

        // Dec seconds tens at 0 wraps to 5
        do_reset();
        set_time(0, 0, 3);
        edit(1, 1'b1);
        chk("dec_sec_tens", obs_time(), 32'h000053);

        // Reset mid-ripple with a pending tick
        do_reset();
        set_time(0, 59, 59);
        i_Edit_Active = 1'b0;
        i_Tick = 1'b1;
        cyc(); cyc();
        i_Tick = 1'b0; i_Reset = 1'b1;
        cyc(); i_Reset = 1'b0;
        chk("midrst_time", obs_time(), 32'h000000);
        chk("midrst_busy", 32'(o_Busy), 0);
        chk("midrst_roll", 32'(o_Rollover), 0);
        chk("midrst_tovr", 32'(o_Tick_Overrun), 0);
        chk("midrst_eovr", 32'(o_Edit_Overrun), 0);
        cyc(); cyc();
        chk("midrst_after_time", obs_time(), 32'h000000);
        chk("midrst_after_busy", 32'(o_Busy), 0);

        // Random edits against the digit model, with occasional inc+dec no-ops
        do_reset();
        i_Edit_Active = 1'b1;
        repeat (80) begin
            int k;
            k = int'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) begin
                i_Digit_Inc[k] = 1'b1; i_Digit_Dec[k] = 1'b1;
                cyc();
                i_Digit_Inc = '0; i_Digit_Dec = '0;
                chk("rnd_nop_ovr", 32'(o_Edit_Overrun), 0);
            end else begin
                edit(k, 1'(($urandom_range(0, 1))));
            end
            chk("rnd_edit_time", obs_time(), bcd(m_h, m_m, m_s));
        end

        // Random-spaced ticks across midnight
        do_reset();
        set_time(23, 59, int'($urandom_range(20, 50)));
        i_Edit_Active = 1'b0;
        cyc();
        repeat (45) begin
            rand_tick();
            repeat ($urandom_range(0, 2)) cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
